if_fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the instruction decoder/control unit.
- Holds the PC and issues word reads to instruction memory (one read per request, responses strictly in order).
- Buffers returned words in a 2-entry queue and presents them to decode through a valid/ready handshake.
- Accepts a redirect (JAL/branch target) from execute and discards any stale fetches.

---
 rtl/if_fetch_unit.sv | 153 +++++++++++++++
 tb/tb_if_fetch_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues in-order word reads to instruction
// memory, tags responses with their PC and hands them to decode via a 2-entry queue.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        fetch_misalign
);

  localparam int         DATA_W  = 32;
  localparam logic [1:0] MAX_OUT = 2'(MAX_OUTSTANDING);

  // p0: request side
  logic [DATA_W-1:0] fetch_pc_p0;

  // p1: requests in flight (live ones carry a PC tag, dropped ones only a count)
  logic [1:0]        outstanding_p1;
  logic [1:0]        drop_p1;
  logic [DATA_W-1:0] tag_pc_p1 [2];
  logic              tag_rd_p1;
  logic              tag_wr_p1;

  // p2: decode queue, head slot always drives the outputs
  logic [1:0]        q_cnt_p2;
  logic [DATA_W-1:0] hd_instr_p2;
  logic [DATA_W-1:0] hd_pc_p2;
  logic [DATA_W-1:0] tl_instr_p2;
  logic [DATA_W-1:0] tl_pc_p2;

  logic              misalign_q;
  logic              grant;
  logic              push;
  logic              pop;
  logic [2:0]        occupancy;
  logic [DATA_W-1:0] push_pc;

  assign imem_addr      = fetch_pc_p0;
  assign instr_valid    = (q_cnt_p2 != 2'd0);
  assign instr_o        = hd_instr_p2;
  assign pc_o           = hd_pc_p2;
  assign fetch_misalign = misalign_q;
  assign push_pc        = tag_pc_p1[tag_rd_p1];

  // A slot freed by this cycle's pop may be reused by this cycle's request,
  // which is what sustains one instruction per cycle.
  always_comb begin
    pop       = instr_valid & instr_ready;
    occupancy = {1'b0, q_cnt_p2} + {1'b0, outstanding_p1} - {2'b00, pop};
    imem_req  = !rst && !redirect_en && (outstanding_p1 < MAX_OUT) && (occupancy < 3'd2);
    grant     = imem_req & imem_gnt;
    push      = imem_rvalid & (drop_p1 == 2'd0) & !redirect_en;
  end

  // p0 -> p1 boundary: PC advance, in-flight bookkeeping, redirect
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_p0    <= RESET_PC;
      outstanding_p1 <= 2'd0;
      drop_p1        <= 2'd0;
      tag_rd_p1      <= 1'b0;
      tag_wr_p1      <= 1'b0;
      misalign_q     <= 1'b0;
    end else begin
      outstanding_p1 <= outstanding_p1 + {1'b0, grant} - {1'b0, imem_rvalid};
      if (redirect_en) begin
        // every request still in flight becomes stale; this cycle's response is discarded too
        fetch_pc_p0 <= {redirect_pc[DATA_W-1:2], 2'b00};
        drop_p1     <= outstanding_p1 - {1'b0, imem_rvalid};
        tag_rd_p1   <= tag_wr_p1;
        if (redirect_pc[1:0] != 2'b00) begin
          misalign_q <= 1'b1;
        end
      end else begin
        if (grant) begin
          fetch_pc_p0 <= fetch_pc_p0 + 32'd4;
          tag_wr_p1   <= ~tag_wr_p1;
        end
        if (imem_rvalid) begin
          if (drop_p1 != 2'd0) begin
            drop_p1 <= drop_p1 - 2'd1;
          end else begin
            tag_rd_p1 <= ~tag_rd_p1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (grant) begin
      tag_pc_p1[tag_wr_p1] <= fetch_pc_p0;
    end
  end

  // p1 -> p2 boundary: shift queue; a flush only clears the count so outputs hold
  always_ff @(posedge clk) begin
    if (rst) begin
      q_cnt_p2    <= 2'd0;
      hd_instr_p2 <= '0;
      hd_pc_p2    <= '0;
      tl_instr_p2 <= '0;
      tl_pc_p2    <= '0;
    end else if (redirect_en) begin
      q_cnt_p2 <= 2'd0;
    end else begin
      case ({push, pop})
        2'b11: begin
          if (q_cnt_p2 == 2'd2) begin
            hd_instr_p2 <= tl_instr_p2;
            hd_pc_p2    <= tl_pc_p2;
            tl_instr_p2 <= imem_rdata;
            tl_pc_p2    <= push_pc;
          end else begin
            hd_instr_p2 <= imem_rdata;
            hd_pc_p2    <= push_pc;
          end
        end
        2'b01: begin
          if (q_cnt_p2 == 2'd2) begin
            hd_instr_p2 <= tl_instr_p2;
            hd_pc_p2    <= tl_pc_p2;
          end
          q_cnt_p2 <= q_cnt_p2 - 2'd1;
        end
        2'b10: begin
          if (q_cnt_p2 == 2'd0) begin
            hd_instr_p2 <= imem_rdata;
            hd_pc_p2    <= push_pc;
          end else begin
            tl_instr_p2 <= imem_rdata;
            tl_pc_p2    <= push_pc;
          end
          q_cnt_p2 <= q_cnt_p2 + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: in-order memory model plus a program-order scoreboard of
// expected fetch/decode PCs, with directed scenarios followed by random traffic.
module tb_if_fetch_unit;

  localparam logic [31:0] RST_PC  = 32'h0000_0000;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;
  localparam int          MAXO    = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, imem_gnt, imem_rvalid, redirect_en, instr_ready;
  logic [31:0] imem_rdata, redirect_pc;
  logic        imem_req, instr_valid, fetch_misalign;
  logic [31:0] imem_addr, instr_o, pc_o;

  logic        w_gnt, w_rvalid, w_redir, w_ready;
  logic [31:0] w_rdata, w_rpc;
  logic        w_req, w_valid, w_mis;
  logic [31:0] w_addr, w_instr, w_pc;

  if_fetch_unit #(.RESET_PC(RST_PC), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .redirect_en(redirect_en),
    .redirect_pc(redirect_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_o(instr_o), .pc_o(pc_o), .fetch_misalign(fetch_misalign)
  );

  if_fetch_unit #(.RESET_PC(WRAP_PC), .MAX_OUTSTANDING(MAXO)) u_wrap (
    .clk(clk), .rst(rst), .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(w_gnt),
    .imem_rvalid(w_rvalid), .imem_rdata(w_rdata), .redirect_en(w_redir),
    .redirect_pc(w_rpc), .instr_valid(w_valid), .instr_ready(w_ready),
    .instr_o(w_instr), .pc_o(w_pc), .fetch_misalign(w_mis)
  );

  int          n_chk = 0, n_fail = 0;
  int          cyc = 0, idle = 0, pops = 0;
  int          gnt_pct, rv_pct;
  logic [31:0] pend_addr[$];
  int          pend_cyc[$];
  logic [31:0] exp_pc, fa_exp;
  logic        mis_exp, prev_wait;
  logic [31:0] wpc[$];
  logic        w_req_q;
  logic [31:0] w_addr_q;
  logic        s_req, s_valid;
  logic [31:0] s_addr, s_pc;

  function automatic logic [31:0] mw(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: memory responds, handshakes are scored, then the edge.
  task automatic tick();
    logic hs_g, pop;
    imem_gnt    = (int'($urandom_range(99)) < gnt_pct);
    imem_rvalid = !rst && pend_addr.size() > 0 && pend_cyc[0] < cyc &&
                  (int'($urandom_range(99)) < rv_pct);
    imem_rdata  = imem_rvalid ? mw(pend_addr[0]) : $urandom();
    w_rvalid    = w_req_q & !rst;
    w_rdata     = mw(w_addr_q);
    #1;
    pop     = instr_valid & instr_ready;
    hs_g    = imem_req & imem_gnt;
    s_req   = imem_req;
    s_addr  = imem_addr;
    s_valid = instr_valid;
    s_pc    = pc_o;
    if (rst) begin
      chk("req_in_rst", {31'd0, imem_req}, 32'd0);
      pend_addr.delete();
      pend_cyc.delete();
      exp_pc    = RST_PC;
      fa_exp    = RST_PC;
      mis_exp   = 1'b0;
      prev_wait = 1'b0;
      idle      = 0;
      wpc.delete();
    end else begin
      chk("misalign", {31'd0, fetch_misalign}, {31'd0, mis_exp});
      if (imem_req) chk("imem_addr", imem_addr, fa_exp);
      if (prev_wait && !redirect_en) chk("req_hold", {31'd0, imem_req}, 32'd1);
      if (redirect_en) chk("req_in_redirect", {31'd0, imem_req}, 32'd0);
      if (pop) begin
        chk("pc_o", pc_o, exp_pc);
        chk("instr_o", instr_o, mw(exp_pc));
        exp_pc += 32'd4;
        idle = 0;
        pops++;
      end else begin
        idle++;
      end
      if (hs_g) begin
        chk("outstanding", {31'd0, pend_addr.size() < MAXO}, 32'd1);
        pend_addr.push_back(imem_addr);
        pend_cyc.push_back(cyc);
        fa_exp += 32'd4;
      end
      if (imem_rvalid) begin
        void'(pend_addr.pop_front());
        void'(pend_cyc.pop_front());
      end
      if (redirect_en) begin
        exp_pc  = {redirect_pc[31:2], 2'b00};
        fa_exp  = {redirect_pc[31:2], 2'b00};
        mis_exp = mis_exp | (redirect_pc[1:0] != 2'b00);
      end
      prev_wait = imem_req & !imem_gnt;
      if (idle > 200) begin
        chk("stall", idle, 32'd0);
        idle = 0;
      end
      if (w_valid && wpc.size() < 3) begin
        wpc.push_back(w_pc);
        chk("wrap_instr", w_instr, mw(w_pc));
        chk("wrap_misalign", {31'd0, w_mis}, 32'd0);
      end
    end
    w_req_q  = w_req & !rst;
    w_addr_q = w_addr;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] wexp [3];
    wexp = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    rst = 1'b1; redirect_en = 1'b0; redirect_pc = '0; instr_ready = 1'b1;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    w_gnt = 1'b1; w_redir = 1'b0; w_rpc = '0; w_ready = 1'b1;
    w_rvalid = 1'b0; w_rdata = '0; w_req_q = 1'b0; w_addr_q = '0;
    gnt_pct = 100; rv_pct = 100;
    @(negedge clk);

    // reset values, then free run at one instruction per cycle
    tick();
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr_o, 32'd0);
    chk("rst_pc", pc_o, 32'd0);
    chk("rst_misalign", {31'd0, fetch_misalign}, 32'd0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("first_valid", {31'd0, s_valid}, {31'd0, k >= 2});
      if (k >= 2) chk("stream_pc", s_pc, 32'(4 * (k - 2)));
    end
    for (int i = 0; i < 3; i++)
      chk("wrap_pc", (wpc.size() > i) ? wpc[i] : 32'hDEAD_BEEF, wexp[i]);

    // backpressure: queue fills with 0,4 and requests stop
    rst = 1'b1; tick(); rst = 1'b0;
    instr_ready = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    chk("bp_req", {31'd0, s_req}, 32'd0);
    chk("bp_valid", {31'd0, s_valid}, 32'd1);
    chk("bp_head", s_pc, 32'd0);
    instr_ready = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    chk("bp_resume", s_pc, 32'd8);

    // redirect while 8 and C are in flight
    rst = 1'b1; tick(); rst = 1'b0;
    rv_pct = 0;
    redirect_en = 1'b1; redirect_pc = 32'h8; tick(); redirect_en = 1'b0;
    tick(); tick(); tick();
    chk("req_at_max", {31'd0, s_req}, 32'd0);
    rv_pct = 100;
    redirect_en = 1'b1; redirect_pc = 32'h100; tick(); redirect_en = 1'b0;
    tick();
    chk("redir_req", {31'd0, s_req}, 32'd1);
    chk("redir_addr", s_addr, 32'h100);
    tick(); tick();
    chk("redir_valid", {31'd0, s_valid}, 32'd1);
    chk("redir_pc", s_pc, 32'h100);

    // misaligned redirect is aligned down and flagged stickily
    redirect_en = 1'b1; redirect_pc = 32'h202; tick(); redirect_en = 1'b0;
    tick();
    chk("mis_addr", s_addr, 32'h200);
    chk("mis_flag", {31'd0, fetch_misalign}, 32'd1);
    for (int k = 0; k < 10; k++) tick();
    chk("mis_sticky", {31'd0, fetch_misalign}, 32'd1);

    // reset in the middle of streaming traffic
    rst = 1'b1; tick();
    chk("midrst_valid", {31'd0, instr_valid}, 32'd0);
    chk("midrst_misalign", {31'd0, fetch_misalign}, 32'd0);
    tick();
    chk("midrst_req", {31'd0, s_req}, 32'd0);
    rst = 1'b0; tick();
    chk("restart_req", {31'd0, s_req}, 32'd1);
    chk("restart_addr", s_addr, RST_PC);

    // random traffic with redirects (some misaligned or near the top of memory) and resets
    gnt_pct = 60; rv_pct = 50;
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = int'($urandom_range(999));
      instr_ready = (int'($urandom_range(99)) < 70);
      rst         = (r < 5);
      redirect_en = !rst && (r < 35);
      redirect_pc = (r & 1) ? (32'hFFFF_FFF0 + 32'($urandom_range(15)))
                            : {20'd0, 12'($urandom())};
      tick();
    end
    rst = 1'b0; redirect_en = 1'b0;
    chk("progress", {31'd0, pops > 500}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
